// File: rtl/redmule_pkg.sv
// Shared types and helpers for the RedMulE TCDM responder.
package redmule_pkg;

   localparam int unsigned TCDM_RESP_MP     = 4;
   localparam int unsigned TCDM_RESP_BANK_W = $clog2(TCDM_RESP_MP);
   localparam logic [15:0] TCDM_RESP_LFSR_SEED = 16'hACE1;

   typedef logic [TCDM_RESP_BANK_W-1:0] tcdm_resp_bank_sel_t;

   typedef struct packed {
      tcdm_resp_bank_sel_t bank;
      logic [31:0]         row;
      logic                err;
   } tcdm_resp_map_t;

   // Word-interleaved mapping: consecutive words land in consecutive banks.
   function automatic tcdm_resp_map_t tcdm_resp_map(input logic [31:0] add,
                                                    input logic [31:0] base,
                                                    input int unsigned bw_log2,
                                                    input int unsigned num_words);
      tcdm_resp_map_t res;
      logic [31:0]    word;
      word     = (add - base) >> bw_log2;
      res.bank = tcdm_resp_bank_sel_t'(word);
      res.row  = word >> TCDM_RESP_BANK_W;
      res.err  = (add < base) || (res.row >= num_words);
      return res;
   endfunction

endpackage

// File: rtl/redmule_tcdm_bank.sv
// One SRAM bank: byte-enable write, registered single-cycle read. Contents are not reset.
module redmule_tcdm_bank #(
   parameter int unsigned PW       = 32,
   parameter int unsigned NumWords = 1024
) (
   input  logic                        clk_i,
   input  logic                        en_i,
   input  logic                        we_i,
   input  logic [$clog2(NumWords)-1:0] row_i,
   input  logic [PW/8-1:0]             be_i,
   input  logic [PW-1:0]               wdata_i,
   output logic [PW-1:0]               rdata_o
);

   logic [PW-1:0] mem [NumWords];
   logic [PW-1:0] rdata_q;

   // Write selected bytes, or capture the addressed row for next-cycle read data.
   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) begin
            for (int i = 0; i < PW / 8; i++) begin
               if (be_i[i]) mem[row_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
            end
         end else begin
            rdata_q <= mem[row_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/redmule_tcdm_responder.sv
// Multi-port banked TCDM responder with per-bank round-robin arbitration and 1-cycle latency.
// Optional random grant stalls are enabled with `define REDMULE_TCDM_RESP_STALL_EN.
module redmule_tcdm_responder
   import redmule_pkg::*;
#(
   parameter int unsigned MP       = TCDM_RESP_MP,
   parameter int unsigned DW       = 128,
   parameter int unsigned AW       = 32,
   parameter int unsigned NumWords = 1024,
   parameter logic [31:0] BaseAddr = 32'h1000_0000
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic [MP-1:0]          tcdm_req_i,
   output logic [MP-1:0]          tcdm_gnt_o,
   input  logic [MP*AW-1:0]       tcdm_add_i,
   input  logic [MP-1:0]          tcdm_wen_i,
   input  logic [DW/8-1:0]        tcdm_be_i,
   input  logic [DW-1:0]          tcdm_data_i,
   output logic [DW-1:0]          tcdm_r_data_o,
   output logic [MP-1:0]          tcdm_r_valid_o,
   output logic                   tcdm_r_opc_o,
   output logic                   tcdm_r_user_o
);

   localparam int unsigned PW     = DW / MP;
   localparam int unsigned BW     = PW / 8;
   localparam int unsigned BwLog2 = $clog2(BW);
   localparam int unsigned RowW   = $clog2(NumWords);

   tcdm_resp_map_t      map [MP];
   tcdm_resp_bank_sel_t ptr_q [MP];
   tcdm_resp_bank_sel_t win [MP];
   tcdm_resp_bank_sel_t bank_q [MP];
   tcdm_resp_bank_sel_t idx;
   logic [MP-1:0]       found, stall, bank_go;
   logic [MP-1:0]       valid_q, read_q, err_q;
   logic [MP-1:0]       bank_en, bank_we;
   logic [RowW-1:0]     bank_row [MP];
   logic [BW-1:0]       bank_be [MP];
   logic [PW-1:0]       bank_wdata [MP];
   logic [PW-1:0]       bank_rdata [MP];

   // Decode every port address into bank, row and error flag.
   always_comb begin
      for (int p = 0; p < MP; p++) begin
         map[p] = tcdm_resp_map(tcdm_add_i[p*AW +: AW], BaseAddr, BwLog2, NumWords);
      end
   end

`ifdef REDMULE_TCDM_RESP_STALL_EN
   logic [15:0] lfsr_q;

   // Free-running Fibonacci LFSR, taps 16/14/13/11.
   always_ff @(posedge clk_i) begin
      if (rst_i) lfsr_q <= TCDM_RESP_LFSR_SEED;
      else       lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end

   // A bank stalls when its two LFSR bits are both zero.
   always_comb begin
      for (int b = 0; b < MP; b++) stall[b] = (lfsr_q[b*2 +: 2] == 2'b00);
   end
`else
   assign stall = '0;
`endif

   // Per bank: first requester at or after the RR pointer wins; mux its access into the bank.
   always_comb begin
      tcdm_gnt_o = '0;
      idx        = '0;
      for (int b = 0; b < MP; b++) begin
         found[b] = 1'b0;
         win[b]   = '0;
         for (int k = 0; k < MP; k++) begin
            idx = tcdm_resp_bank_sel_t'(int'(ptr_q[b]) + k);
            if (!found[b] && tcdm_req_i[idx] && (map[idx].bank == tcdm_resp_bank_sel_t'(b))) begin
               found[b] = 1'b1;
               win[b]   = idx;
            end
         end
         bank_go[b]    = found[b] && !stall[b];
         bank_en[b]    = bank_go[b] && !map[win[b]].err && !rst_i;
         bank_we[b]    = !tcdm_wen_i[win[b]];
         bank_row[b]   = map[win[b]].row[RowW-1:0];
         bank_be[b]    = tcdm_be_i[win[b]*BW +: BW];
         bank_wdata[b] = tcdm_data_i[win[b]*PW +: PW];
         if (bank_go[b]) tcdm_gnt_o[win[b]] = 1'b1;
      end
   end

   // Advance each bank's RR pointer past the winner on a grant.
   always_ff @(posedge clk_i) begin
      for (int b = 0; b < MP; b++) begin
         if (rst_i)           ptr_q[b] <= '0;
         else if (bank_go[b]) ptr_q[b] <= win[b] + 1'b1;
      end
   end

   // Response pipeline: remember what each granted port needs to see next cycle.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         valid_q <= '0;
         read_q  <= '0;
         err_q   <= '0;
         for (int p = 0; p < MP; p++) bank_q[p] <= '0;
      end else begin
         valid_q <= tcdm_gnt_o;
         read_q  <= tcdm_wen_i;
         for (int p = 0; p < MP; p++) begin
            err_q[p]  <= map[p].err;
            bank_q[p] <= map[p].bank;
         end
      end
   end

   for (genvar b = 0; b < MP; b++) begin : g_bank
      redmule_tcdm_bank #(
         .PW       (PW),
         .NumWords (NumWords)
      ) u_bank (
         .clk_i   (clk_i),
         .en_i    (bank_en[b]),
         .we_i    (bank_we[b]),
         .row_i   (bank_row[b]),
         .be_i    (bank_be[b]),
         .wdata_i (bank_wdata[b]),
         .rdata_o (bank_rdata[b])
      );
   end

   // Only clean reads return data; writes and errored accesses return zero.
   always_comb begin
      tcdm_r_data_o = '0;
      for (int p = 0; p < MP; p++) begin
         if (valid_q[p] && read_q[p] && !err_q[p]) tcdm_r_data_o[p*PW +: PW] = bank_rdata[bank_q[p]];
      end
   end

   assign tcdm_r_valid_o = valid_q;
   assign tcdm_r_opc_o   = |(valid_q & err_q);
   assign tcdm_r_user_o  = 1'b0;

endmodule

// File: tb/tb_redmule_tcdm_responder.sv
// Directed self-checking bench for redmule_tcdm_responder (default build, 4 ports x 32 bit).
module tb_redmule_tcdm_responder;

   localparam int unsigned MP   = 4;
   localparam int unsigned DW   = 128;
   localparam logic [31:0] BASE = 32'h1000_0000;

   logic           clk = 1'b0;
   logic           rst;
   logic [3:0]     req, gnt, wen, r_valid;
   logic [127:0]   add, data, r_data;
   logic [15:0]    be;
   logic           r_opc, r_user;

   int n_cmp = 0;
   int n_bad = 0;

   redmule_tcdm_responder #(
      .MP       (MP),
      .DW       (DW),
      .AW       (32),
      .NumWords (1024),
      .BaseAddr (BASE)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .tcdm_req_i     (req),
      .tcdm_gnt_o     (gnt),
      .tcdm_add_i     (add),
      .tcdm_wen_i     (wen),
      .tcdm_be_i      (be),
      .tcdm_data_i    (data),
      .tcdm_r_data_o  (r_data),
      .tcdm_r_valid_o (r_valid),
      .tcdm_r_opc_o   (r_opc),
      .tcdm_r_user_o  (r_user)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(input int p, input logic [31:0] a, input logic w,
                           input logic [3:0] b, input logic [31:0] d);
      req[p]         = 1'b1;
      add[p*32 +: 32] = a;
      wen[p]         = w;
      be[p*4 +: 4]   = b;
      data[p*32 +: 32] = d;
   endtask

   initial begin
      rst = 1'b1; req = '0; add = '0; wen = '0; be = '0; data = '0;

      // Reset behaviour
      repeat (3) step();
      check("rst_valid", 128'(r_valid), 128'(4'h0));
      check("rst_opc", 128'(r_opc), 128'(1'b0));
      check("rst_data", r_data, 128'h0);
      rst = 1'b0;
      step();
      #1 check("idle_gnt", 128'(gnt), 128'(4'h0));
      check("idle_valid", 128'(r_valid), 128'(4'h0));
      check("user_tie", 128'(r_user), 128'(1'b0));

      // Wide aligned write, all banks in one cycle
      for (int i = 0; i < 4; i++) set_port(i, BASE + 32'(4 * i), 1'b0, 4'hF, 32'hDEAD_0000 + 32'(i));
      #1 check("wide_wr_gnt", 128'(gnt), 128'(4'hF));
      step();
      req = '0;
      check("wide_wr_valid", 128'(r_valid), 128'(4'hF));
      check("wide_wr_data0", r_data, 128'h0);

      // Wide read back
      for (int i = 0; i < 4; i++) set_port(i, BASE + 32'(4 * i), 1'b1, 4'h0, 32'h0);
      #1 check("wide_rd_gnt", 128'(gnt), 128'(4'hF));
      step();
      req = '0;
      check("wide_rd_valid", 128'(r_valid), 128'(4'hF));
      check("wide_rd_data", r_data, 128'hDEAD_0003_DEAD_0002_DEAD_0001_DEAD_0000);
      check("wide_rd_opc", 128'(r_opc), 128'(1'b0));

      // Bank conflict from a freshly reset pointer: 0,2,0,2
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_port(0, BASE + 32'h10, 1'b1, 4'h0, 32'h0);
      set_port(2, BASE + 32'h10, 1'b1, 4'h0, 32'h0);
      for (int k = 0; k < 4; k++) begin
         logic [3:0] exp_g;
         exp_g = (k % 2 == 0) ? 4'b0001 : 4'b0100;
         #1 check($sformatf("rr_gnt%0d", k), 128'(gnt), 128'(exp_g));
         step();
         check($sformatf("rr_valid%0d", k), 128'(r_valid), 128'(exp_g));
      end
      req = '0;
      step();

      // Byte enables
      set_port(0, BASE, 1'b0, 4'hF, 32'h1122_3344);
      #1 check("be_wr1_gnt", 128'(gnt), 128'(4'h1));
      step();
      set_port(0, BASE, 1'b0, 4'b0010, 32'hFFFF_FFFF);
      step();
      set_port(0, BASE, 1'b1, 4'h0, 32'h0);
      step();
      req = '0;
      check("be_rd_data", r_data, 128'h1122_FF44);

      // Error addresses: below base and one past the end
      set_port(0, BASE - 32'd4, 1'b1, 4'h0, 32'h0);
      #1 check("err_lo_gnt", 128'(gnt), 128'(4'h1));
      step();
      req = '0;
      check("err_lo_valid", 128'(r_valid), 128'(4'h1));
      check("err_lo_data", r_data, 128'h0);
      check("err_lo_opc", 128'(r_opc), 128'(1'b1));
      set_port(0, BASE + 32'h4000, 1'b1, 4'h0, 32'h0);
      #1 check("err_hi_gnt", 128'(gnt), 128'(4'h1));
      step();
      req = '0;
      check("err_hi_data", r_data, 128'h0);
      check("err_hi_opc", 128'(r_opc), 128'(1'b1));
      // Out-of-range writes must not alias onto row 0
      set_port(0, BASE + 32'h4000, 1'b0, 4'hF, 32'h0);
      step();
      set_port(0, BASE - 32'd4, 1'b0, 4'hF, 32'h0);
      step();
      check("err_wr_opc", 128'(r_opc), 128'(1'b1));
      set_port(0, BASE, 1'b1, 4'h0, 32'h0);
      step();
      req = '0;
      check("err_wr_kept", r_data, 128'h1122_FF44);
      check("err_wr_opc0", 128'(r_opc), 128'(1'b0));

      // Reset in the cycle a write is granted
      set_port(0, BASE, 1'b0, 4'hF, 32'hCAFE_BABE);
      rst = 1'b1;
      step();
      rst = 1'b0;
      req = '0;
      check("rst_wr_valid", 128'(r_valid), 128'(4'h0));
      set_port(0, BASE, 1'b1, 4'h0, 32'h0);
      step();
      req = '0;
      check("rst_wr_valid2", 128'(r_valid), 128'(4'h1));
      check("rst_wr_kept", r_data, 128'h1122_FF44);

      step();
      check("final_idle", 128'(r_valid), 128'(4'h0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
